// File: rtl/led_pattern_ctrl_pkg.sv
// Shared types and defaults for the LED pattern controller.
package led_pattern_ctrl_pkg;

  typedef enum logic [1:0] {
    ModeStatic = 2'd0,
    ModeBlink  = 2'd1,
    ModeRotL   = 2'd2,
    ModeRotR   = 2'd3
  } led_mode_e;

  localparam int unsigned DefaultPrescale = 50000;
  localparam logic [7:0]  DutyFull        = 8'd255;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 and flags the wrap cycle with a one-cycle tick.
module led_tick_gen #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CntW-1:0] r_cnt;
  logic            w_wrap;

  assign w_wrap = (r_cnt == CntW'(PRESCALE - 1));
  assign o_tick = w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: latches a config snapshot on cfg_update and drives static/blink/rotate
// patterns. Optional PWM dimming is enabled by defining LED_PATTERN_CTRL_PWM_EN.
module led_pattern_ctrl
  import led_pattern_ctrl_pkg::*;
#(
  parameter int unsigned LED_W    = 8,
  parameter int unsigned PRESCALE = DefaultPrescale,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LED_W-1:0]    i_cfg_value,
  input  logic [1:0]          i_cfg_mode,
  input  logic [PERIOD_W-1:0] i_cfg_period,
  input  logic [7:0]          i_cfg_duty,
  input  logic                i_cfg_update,
  output logic [LED_W-1:0]    o_led,
  output logic                o_step_pulse
);

  logic [LED_W-1:0]    r_value;
  led_mode_e           r_mode;
  logic [PERIOD_W-1:0] r_period;
  logic [7:0]          r_duty;

  logic [PERIOD_W-1:0] r_step_cnt;
  logic [LED_W-1:0]    r_pat;
  logic                r_phase;
  logic [LED_W-1:0]    r_led;
  logic                r_step_pulse;

  logic                w_tick;
  logic [PERIOD_W-1:0] w_period_m1;
  logic                w_step_last;
  logic                w_step;
  logic [LED_W-1:0]    w_pat_next;
  logic                w_phase_next;
  logic [LED_W-1:0]    w_pattern;
  logic [LED_W-1:0]    w_led_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value  <= '0;
      r_mode   <= ModeStatic;
      r_period <= PERIOD_W'(1);
      r_duty   <= DutyFull;
    end else if (i_cfg_update) begin
      r_value  <= i_cfg_value;
      r_mode   <= led_mode_e'(i_cfg_mode);
      r_period <= i_cfg_period;
      r_duty   <= i_cfg_duty;
    end
  end

  led_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (i_cfg_update),
    .o_tick  (w_tick)
  );

  // Period 0 folds onto period 1.
  assign w_period_m1 = (r_period == '0) ? '0 : r_period - PERIOD_W'(1);
  assign w_step_last = (r_step_cnt >= w_period_m1);
  // A restart on the same edge as a step suppresses the step.
  assign w_step      = w_tick && w_step_last && !i_cfg_update;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_cnt <= '0;
    end else if (i_cfg_update) begin
      r_step_cnt <= '0;
    end else if (w_tick) begin
      r_step_cnt <= w_step_last ? '0 : r_step_cnt + PERIOD_W'(1);
    end
  end

  always_comb begin
    w_pat_next   = r_pat;
    w_phase_next = r_phase;
    case (r_mode)
      ModeBlink: w_phase_next = ~r_phase;
      ModeRotL:  w_pat_next   = {r_pat[LED_W-2:0], r_pat[LED_W-1]};
      ModeRotR:  w_pat_next   = {r_pat[0], r_pat[LED_W-1:1]};
      default:   w_pat_next   = r_pat;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat   <= '0;
      r_phase <= 1'b0;
    end else if (i_cfg_update) begin
      r_pat   <= i_cfg_value;
      r_phase <= 1'b0;
    end else if (w_step) begin
      r_pat   <= w_pat_next;
      r_phase <= w_phase_next;
    end
  end

  assign w_pattern = ((r_mode == ModeBlink) && r_phase) ? '0 : r_pat;

`ifdef LED_PATTERN_CTRL_PWM_EN
  logic [7:0] r_pwm_cnt;
  logic       w_pwm_on;

  // Free-running 255-cycle PWM frame; not restarted by cfg_update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
    end else if (r_pwm_cnt == 8'd254) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
  end

  assign w_pwm_on   = (r_pwm_cnt < r_duty);
  assign w_led_next = w_pattern & {LED_W{w_pwm_on}};
`else
  logic w_unused_duty;

  assign w_unused_duty = ^r_duty;
  assign w_led_next    = w_pattern;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led        <= '0;
      r_step_pulse <= 1'b0;
    end else begin
      r_led        <= w_led_next;
      r_step_pulse <= w_step;
    end
  end

  assign o_led        = r_led;
  assign o_step_pulse = r_step_pulse;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with PRESCALE=4: vector table plus hand-written corner cases.
module tb_led_pattern_ctrl;
  import led_pattern_ctrl_pkg::*;

  localparam int unsigned LedW    = 8;
  localparam int unsigned Pre     = 4;
  localparam int unsigned PeriodW = 16;
  localparam int unsigned NumVecs = 20;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  value;
    logic [15:0] period;
    int unsigned wait_n;
    logic [7:0]  exp_led;
    logic        exp_step;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [LedW-1:0]   cfg_value = '0;
  logic [1:0]        cfg_mode = '0;
  logic [PeriodW-1:0] cfg_period = '0;
  logic [7:0]        cfg_duty = 8'd255;
  logic              cfg_update = 1'b0;
  logic [LedW-1:0]   led;
  logic              step_pulse;

  int n_checks = 0;
  int n_errors = 0;

  vec_t vecs [NumVecs];

  led_pattern_ctrl #(
    .LED_W    (LedW),
    .PRESCALE (Pre),
    .PERIOD_W (PeriodW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cfg_value  (cfg_value),
    .i_cfg_mode   (cfg_mode),
    .i_cfg_period (cfg_period),
    .i_cfg_duty   (cfg_duty),
    .i_cfg_update (cfg_update),
    .o_led        (led),
    .o_step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_led(input string name, input logic [7:0] exp);
    n_checks++;
    if (led !== exp) begin
      n_errors++;
      $display("FAIL %s: led got %02h expected %02h", name, led, exp);
    end
  endtask

  task automatic check_step(input string name, input logic exp);
    n_checks++;
    if (step_pulse !== exp) begin
      n_errors++;
      $display("FAIL %s: step_pulse got %b expected %b", name, step_pulse, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Returns 1 ns after the strobe edge k.
  task automatic strobe(input logic [1:0] mode, input logic [7:0] val, input logic [15:0] per,
                        input logic [7:0] duty);
    @(negedge clk);
    cfg_mode   = mode;
    cfg_value  = val;
    cfg_period = per;
    cfg_duty   = duty;
    cfg_update = 1'b1;
    @(posedge clk);
    #1;
    cfg_update = 1'b0;
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;

    vecs[0]  = '{2'd2, 8'h01, 16'd2, 1,  8'h01, 1'b0};
    vecs[1]  = '{2'd2, 8'h01, 16'd2, 8,  8'h01, 1'b1};
    vecs[2]  = '{2'd2, 8'h01, 16'd2, 9,  8'h02, 1'b0};
    vecs[3]  = '{2'd2, 8'h01, 16'd2, 17, 8'h04, 1'b0};
    vecs[4]  = '{2'd2, 8'h01, 16'd2, 57, 8'h80, 1'b0};
    vecs[5]  = '{2'd2, 8'h01, 16'd2, 65, 8'h01, 1'b0};
    vecs[6]  = '{2'd1, 8'hA5, 16'd1, 1,  8'hA5, 1'b0};
    vecs[7]  = '{2'd1, 8'hA5, 16'd1, 4,  8'hA5, 1'b1};
    vecs[8]  = '{2'd1, 8'hA5, 16'd1, 5,  8'h00, 1'b0};
    vecs[9]  = '{2'd1, 8'hA5, 16'd1, 8,  8'h00, 1'b1};
    vecs[10] = '{2'd1, 8'hA5, 16'd1, 9,  8'hA5, 1'b0};
    vecs[11] = '{2'd3, 8'h80, 16'd0, 4,  8'h80, 1'b1};
    vecs[12] = '{2'd3, 8'h80, 16'd0, 5,  8'h40, 1'b0};
    vecs[13] = '{2'd3, 8'h80, 16'd0, 9,  8'h20, 1'b0};
    vecs[14] = '{2'd3, 8'h80, 16'd1, 9,  8'h20, 1'b0};
    vecs[15] = '{2'd0, 8'h3C, 16'd3, 12, 8'h3C, 1'b1};
    vecs[16] = '{2'd0, 8'h3C, 16'd3, 13, 8'h3C, 1'b0};
    vecs[17] = '{2'd3, 8'h00, 16'd1, 9,  8'h00, 1'b0};
    vecs[18] = '{2'd2, 8'hFF, 16'd1, 9,  8'hFF, 1'b0};
    vecs[19] = '{2'd3, 8'h81, 16'd1, 5,  8'hC0, 1'b0};

    // Reset state, then 10 ticks with no update.
    #12;
    check_led("reset_led", 8'h00);
    check_step("reset_step", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10 * int'(Pre); i++) begin
      cycles(1);
      check_led("idle_led", 8'h00);
    end

    // Strobe-to-LED latency and update colliding with a pending step.
    strobe(2'd2, 8'h01, 16'd1, 8'd255);
    check_led("lat_k", 8'h00);
    cycles(1);
    check_led("lat_k1", 8'h01);
    cycles(2);
    cfg_value  = 8'h10;
    cfg_update = 1'b1;
    @(posedge clk);
    #1;
    cfg_update = 1'b0;
    check_step("collide_nostep", 1'b0);
    check_led("collide_led_k4", 8'h01);
    for (int i = 5; i < 8; i++) begin
      cycles(1);
      check_step("collide_quiet", 1'b0);
      check_led("collide_newpat", 8'h10);
    end
    cycles(1);
    check_step("collide_next_step", 1'b1);
    check_led("collide_led_k8", 8'h10);
    cycles(1);
    check_led("collide_led_k9", 8'h20);

    // cfg inputs without a strobe are ignored.
    cfg_value = 8'hFF;
    cfg_mode  = 2'd3;
    cycles(4);
    check_led("ignore_cfg", 8'h40);

    // Asynchronous reset mid-cycle.
    #3;
    rst_n = 1'b0;
    #1;
    check_led("async_rst_led", 8'h00);
    check_step("async_rst_step", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycles(Pre);
      check_led("post_rst_led", 8'h00);
    end

    for (int v = 0; v < NumVecs; v++) begin
      strobe(vecs[v].mode, vecs[v].value, vecs[v].period, 8'd255);
      cycles(vecs[v].wait_n);
      check_led($sformatf("vec%0d_led", v), vecs[v].exp_led);
      check_step($sformatf("vec%0d_step", v), vecs[v].exp_step);
    end

`ifdef LED_PATTERN_CTRL_PWM_EN
    strobe(2'd0, 8'hFF, 16'd1, 8'd64);
    cycles(2);
    cnt = 0;
    for (int i = 0; i < 255; i++) begin
      if (led == 8'hFF) cnt++;
      cycles(1);
    end
    check_int("pwm_duty64_on", cnt, 64);
    strobe(2'd0, 8'hFF, 16'd1, 8'd0);
    cycles(2);
    cnt = 0;
    for (int i = 0; i < 255; i++) begin
      if (led != 8'h00) cnt++;
      cycles(1);
    end
    check_int("pwm_duty0_on", cnt, 0);
    strobe(2'd0, 8'hFF, 16'd1, 8'd255);
    cycles(2);
    cnt = 0;
    for (int i = 0; i < 255; i++) begin
      if (led == 8'hFF) cnt++;
      cycles(1);
    end
    check_int("pwm_duty255_on", cnt, 255);
`else
    strobe(2'd0, 8'hFF, 16'd1, 8'd0);
    cycles(2);
    cnt = 0;
    for (int i = 0; i < 255; i++) begin
      if (led == 8'hFF) cnt++;
      cycles(1);
    end
    check_int("nopwm_duty0_on", cnt, 255);
    strobe(2'd0, 8'hFF, 16'd1, 8'd64);
    cycles(2);
    cnt = 0;
    for (int i = 0; i < 255; i++) begin
      if (led == 8'hFF) cnt++;
      cycles(1);
    end
    check_int("nopwm_duty64_on", cnt, 255);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
